// File: rtl/tx_pkg.sv
// Shared transmitter definitions: word layout and the feeder FSM encoding.
package tx_pkg;
    localparam int DATA_W   = 6;
    localparam int VC_BIT   = 5;
    localparam int DEST_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } feeder_state_e;
endpackage

// File: rtl/tx_feeder_if.sv
// Source-side valid/ready handshake plus the push/pause link into the main FIFO.
interface tx_feeder_if;
    import tx_pkg::*;

    // A word moves on a rising edge where in_valid && in_ready; in_data must be stable
    // while in_valid is high. MAIN_PAUSE stalls PUSH_MAIN at the edge it is sampled.
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              MAIN_PAUSE;
    logic              PUSH_MAIN;
    logic [DATA_W-1:0] DATA_IN_TX;

    modport master (
        output in_valid, in_data, MAIN_PAUSE,
        input  in_ready, PUSH_MAIN, DATA_IN_TX
    );

    modport slave (
        input  in_valid, in_data, MAIN_PAUSE,
        output in_ready, PUSH_MAIN, DATA_IN_TX
    );
endinterface

// File: rtl/feeder_skid.sv
// Circular skid buffer with head/tail pointers and an occupancy count.
module feeder_skid
    import tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    assign rd_data = mem[head];
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[tail] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_en) tail <= tail + 1'b1;
            if (rd_en) head <= head + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tx_feeder.sv
// Transmitter feeder: skid-buffers source words and pushes them into the main FIFO.
// Define TX_FEEDER_STATS_EN to build the saturating per-VC push counters.
module tx_feeder
    import tx_pkg::*;
#(
    parameter int SKID_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             RESET_L,
    input  logic             init,
    tx_feeder_if.slave       bus,
    output logic [1:0]       feeder_state,
    output logic [PTR_W:0]   skid_count,
    output logic [CNT_W-1:0] cnt_vc0,
    output logic [CNT_W-1:0] cnt_vc1
);
    feeder_state_e     state;
    logic              accept;
    logic              drain;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head_data;
    logic [PTR_W:0]    count_next;

    // in_ready looks only at registered occupancy, so a same-edge drain never opens it.
    assign bus.in_ready = !full && !init && RESET_L;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = (state == SEND) && !empty && !bus.MAIN_PAUSE && !init;
    assign feeder_state = state;

    feeder_skid #(
        .DEPTH (SKID_DEPTH),
        .PTR_W (PTR_W)
    ) u_skid (
        .clk     (clk),
        .RESET_L (RESET_L),
        .clear   (init),
        .wr_en   (accept),
        .wr_data (bus.in_data),
        .rd_en   (drain),
        .rd_data (head_data),
        .count   (skid_count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        count_next = skid_count;
        if (accept && !drain) begin
            count_next = skid_count + 1'b1;
        end else if (!accept && drain) begin
            count_next = skid_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state          <= IDLE;
            bus.PUSH_MAIN  <= 1'b0;
            bus.DATA_IN_TX <= '0;
        end else if (init) begin
            state         <= IDLE;
            bus.PUSH_MAIN <= 1'b0;
        end else begin
            bus.PUSH_MAIN <= drain;
            if (drain) begin
                bus.DATA_IN_TX <= head_data;
            end
            case (state)
                IDLE: if (skid_count != '0) state <= bus.MAIN_PAUSE ? HOLD : SEND;
                // Leave SEND only once the word leaving at this edge was the last one.
                SEND: begin
                    if (bus.MAIN_PAUSE)         state <= HOLD;
                    else if (count_next == '0)  state <= IDLE;
                end
                HOLD: begin
                    if (skid_count == '0)       state <= IDLE;
                    else if (!bus.MAIN_PAUSE)   state <= SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TX_FEEDER_STATS_EN
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt_vc0 <= '0;
            cnt_vc1 <= '0;
        end else if (init) begin
            cnt_vc0 <= '0;
            cnt_vc1 <= '0;
        end else if (drain) begin
            if (head_data[VC_BIT]) begin
                if (cnt_vc1 != '1) cnt_vc1 <= cnt_vc1 + 1'b1;
            end else begin
                if (cnt_vc0 != '1) cnt_vc0 <= cnt_vc0 + 1'b1;
            end
        end
    end
`else
    assign cnt_vc0 = '0;
    assign cnt_vc1 = '0;
`endif
endmodule
